// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Bundles the fetch-side push signals, the decode-side handshake and the queue
// status outputs of fetch_queue.
//   master : the environment (fetch + decode) driving pushes, flush and ready
//   slave  : the queue itself
// Signals:
//   valid_in/pc_in/insn_in : completed instruction read from memory
//   flush_in               : branch redirect, discards all entries
//   ready_in               : decode accepts the head entry
//   valid_out/pc_out/insn_out/misaligned_out : head entry presented to decode
//   stall_out              : asks fetch to hold its PC
//   count_out              : occupancy
//   overflow_out           : sticky, a push was dropped
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          valid_in;
  logic [31:0]   pc_in;
  logic [31:0]   insn_in;
  logic          flush_in;
  logic          ready_in;
  logic          valid_out;
  logic [31:0]   pc_out;
  logic [31:0]   insn_out;
  logic          misaligned_out;
  logic          stall_out;
  logic [CW-1:0] count_out;
  logic          overflow_out;

  modport master (
    output valid_in, pc_in, insn_in, flush_in, ready_in,
    input  valid_out, pc_out, insn_out, misaligned_out, stall_out,
           count_out, overflow_out
  );

  modport slave (
    input  valid_in, pc_in, insn_in, flush_in, ready_in,
    output valid_out, pc_out, insn_out, misaligned_out, stall_out,
           count_out, overflow_out
  );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// In-order instruction buffer between fetch and decode. Stores up to DEPTH
// {misaligned, pc, insn} entries in a circular buffer, presents the oldest to
// decode with valid/ready, throttles fetch through stall_out and supports a
// branch-redirect flush.
// Parameters:
//   DEPTH    : number of entries (power of two, >= 2)
//   PC_RESET : pc_out value while the queue is empty
// Ports:
//   clk_in : clock, rising edge
//   rst_in : asynchronous active-high reset
//   bus    : fetch_queue_if.slave (push, flush, decode handshake, status)
// Build option:
//   FETCH_QUEUE_BYPASS_EN : when defined, a word arriving at an empty queue is
//   shown to decode in the same cycle and is not stored if decode takes it.
//   When undefined, the head outputs depend on registered state only.
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic          clk_in,
  input  logic          rst_in,
  fetch_queue_if.slave  bus
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_CNT = (AW+1)'(DEPTH - 1);

  typedef struct packed {
    logic        mis;
    logic [31:0] pc;
    logic [31:0] insn;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          overflow;

  entry_t in_entry;
  entry_t head;
  logic   empty;
  logic   full;
  logic   bypass_hit;
  logic   bypass_take;
  logic   pop;
  logic   push;
  logic   drop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign in_entry = '{mis: |bus.pc_in[1:0], pc: bus.pc_in, insn: bus.insn_in};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = empty && bus.valid_in && !bus.flush_in;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed word taken by decode is neither stored nor popped, so the
  // pointers and count are left alone for that cycle.
  assign bypass_take = bypass_hit && bus.ready_in;
  assign pop         = !empty && bus.ready_in && !bus.flush_in;
  assign push        = bus.valid_in && !bus.flush_in && (!full || pop) && !bypass_take;
  assign drop        = bus.valid_in && !bus.flush_in && full && !pop;

  // Head selection: the bypassed input, the stored head, or the idle values.
  always_comb begin
    head = '{mis: 1'b0, pc: PC_RESET, insn: 32'h0};
    if (bypass_hit)  head = in_entry;
    else if (!empty) head = mem[rd_ptr];
  end

  assign bus.valid_out      = !empty || bypass_hit;
  assign bus.pc_out         = head.pc;
  assign bus.insn_out       = head.insn;
  assign bus.misaligned_out = head.mis;
  // Fetch registers its PC one cycle after sampling stall, so one free slot
  // must remain when stall rises.
  assign bus.stall_out      = (count >= STALL_CNT);
  assign bus.count_out      = count;
  assign bus.overflow_out   = overflow;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (bus.flush_in) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are only observed
  // through valid entries, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= in_entry;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue (DEPTH=4). A driver applies directed and
// random stimulus on the falling edge and updates a queue-based reference
// model; words expected to leave the queue go into a scoreboard. A monitor
// samples just after each falling edge, checks the status outputs and pops the
// scoreboard on every decode handshake.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] PC_RST = 32'h0001_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } word_t;

  logic clk_in = 1'b0;
  logic rst_in;

  always #5 clk_in = ~clk_in;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .PC_RESET(PC_RST)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  word_t ref_q[$];
  word_t sb_q[$];
  bit    ref_ovf;
  int    exp_n;
  bit    exp_ovf;
  bit    exp_byp;
  bit    drove;
  int    n_tests;
  int    n_fail;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model moves to the state after the next edge.
  task automatic cycle(bit v, logic [31:0] pc, logic [31:0] insn, bit fl, bit rdy);
    int    n;
    bit    byp, take, pop;
    word_t w;
    @(negedge clk_in);
    bus.valid_in = v;
    bus.pc_in    = pc;
    bus.insn_in  = insn;
    bus.flush_in = fl;
    bus.ready_in = rdy;
    n       = ref_q.size();
    exp_n   = n;
    exp_ovf = ref_ovf;
    w.pc    = pc;
    w.insn  = insn;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (n == 0) && v && !fl;
`else
    byp = 1'b0;
`endif
    exp_byp = byp;
    take    = byp && rdy;
    pop     = (n > 0) && rdy && !fl;
    if (take) sb_q.push_back(w);
    if (pop)  sb_q.push_back(ref_q.pop_front());
    if (fl) ref_q.delete();
    else if (v && !take) begin
      if (n < DEPTH || pop) ref_q.push_back(w);
      else                  ref_ovf = 1'b1;
    end
    drove = 1'b1;
  endtask

  task automatic idle(bit rdy);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, rdy);
  endtask

  // Reset pulse between two rising edges with immediate output checks.
  task automatic pulse_reset();
    @(negedge clk_in);
    drove        = 1'b0;
    bus.valid_in = 1'b0;
    bus.flush_in = 1'b0;
    bus.ready_in = 1'b0;
    rst_in       = 1'b1;
    #2;
    check("rst_valid", 64'(bus.valid_out), 64'd0);
    check("rst_count", 64'(bus.count_out), 64'd0);
    check("rst_stall", 64'(bus.stall_out), 64'd0);
    check("rst_ovf",   64'(bus.overflow_out), 64'd0);
    check("rst_pc",    64'(bus.pc_out), 64'(PC_RST));
    check("rst_insn",  64'(bus.insn_out), 64'd0);
    #1;
    rst_in = 1'b0;
    ref_q.delete();
    sb_q.delete();
    ref_ovf = 1'b0;
  endtask

  // Monitor: status checks every driven cycle, scoreboard pop per handshake.
  initial begin
    word_t w;
    forever begin
      @(negedge clk_in);
      #2;
      if (!rst_in && drove) begin
        drove = 1'b0;
        check("count",    64'(bus.count_out), 64'(exp_n));
        check("stall",    64'(bus.stall_out), 64'(exp_n >= DEPTH - 1));
        check("overflow", 64'(bus.overflow_out), 64'(exp_ovf));
        check("valid",    64'(bus.valid_out), 64'((exp_n > 0) || exp_byp));
        if (bus.valid_out && bus.ready_in && !bus.flush_in) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pop: got pc %0h expected no handshake", bus.pc_out);
          end else begin
            w = sb_q.pop_front();
            check("head_pc",   64'(bus.pc_out), 64'(w.pc));
            check("head_insn", 64'(bus.insn_out), 64'(w.insn));
            check("head_mis",  64'(bus.misaligned_out), 64'(|w.pc[1:0]));
          end
        end else if (!bus.valid_out) begin
          check("empty_pc",   64'(bus.pc_out), 64'(PC_RST));
          check("empty_insn", 64'(bus.insn_out), 64'd0);
          check("empty_mis",  64'(bus.misaligned_out), 64'd0);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    n_tests      = 0;
    n_fail       = 0;
    drove        = 1'b0;
    ref_ovf      = 1'b0;
    rst_in       = 1'b1;
    bus.valid_in = 1'b0;
    bus.pc_in    = '0;
    bus.insn_in  = '0;
    bus.flush_in = 1'b0;
    bus.ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    #1 rst_in = 1'b0;
    idle(1'b0);

    // Reset mid-stream after three pushes.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h9000_0000 + 32'(4*i), 32'hA0 + 32'(i), 1'b0, 1'b0);
    pulse_reset();
    idle(1'b0);

    // In-order fill then drain.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h8002_0000 + 32'(4*i), 32'h1111_1111 * 32'(i+1), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Full queue: push+pop keeps count, then push without pop drops.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h8002_0100 + 32'(4*i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h8002_0010, 32'h5555_5555, 1'b0, 1'b1);
    cycle(1'b1, 32'h8002_0014, 32'h6666_6666, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Flush together with a push: the pushed word never appears.
    cycle(1'b1, 32'h8002_0200, 32'hC000_0000, 1'b0, 1'b0);
    cycle(1'b1, 32'h8002_0204, 32'hC000_0001, 1'b0, 1'b0);
    cycle(1'b1, 32'h8002_0208, 32'hDEAD_BEEF, 1'b1, 1'b1);
    idle(1'b0);
    cycle(1'b1, 32'h8002_0300, 32'hC000_0002, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Wrap-around with one misaligned PC.
    cycle(1'b1, 32'h8002_0400, 32'hE000_0000, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      pc = (i == 5) ? 32'h8002_0006 : 32'h8002_0400 + 32'(4*i);
      cycle(1'b1, pc, 32'hE000_0000 + 32'(i), 1'b0, 1'b1);
    end
    idle(1'b1);
    idle(1'b1);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Bypass: empty queue, word taken in the same cycle.
    cycle(1'b1, 32'h8002_0000, 32'h7777_7777, 1'b0, 1'b1);
    idle(1'b0);
`endif

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      pc = $urandom;
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      cycle(($urandom_range(0, 3) != 0), pc, $urandom,
            ($urandom_range(0, 40) == 0), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    @(negedge clk_in);
    #3;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check("model_empty_count",  64'(bus.count_out), 64'(ref_q.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and decode. It captures each {PC, instruction word} pair returned from main memory for a fetch read and buffers up to DEPTH entries in order. It presents the oldest entry to decode with a valid/ready handshake and drives `stall_out` back to fetch so that no fetched instruction is lost. It also supports a branch-redirect flush.

## Interface
- `DEPTH`, 4: number of entries; power of two, minimum 2.
- `PC_RESET`, 32'h00000000: value driven on `pc_out` while the queue is empty after reset or flush.

- `clk_in`, input, 1: clock; all state updates on the rising edge.
- `rst_in`, input, 1: asynchronous, active-high reset.
- `valid_in`, input, 1: fetch/memory presents a completed instruction read this cycle.
- `pc_in`, input, 32: address of the instruction being presented.
- `insn_in`, input, 32: instruction word read from main memory.
- `flush_in`, input, 1: discards all entries, including any push in the same cycle.
- `ready_in`, input, 1: decode accepts the head entry this cycle.
- `valid_out`, output, 1: the head entry is valid.
- `pc_out`, output, 32: PC of the head entry.
- `insn_out`, output, 32: instruction of the head entry.
- `misaligned_out`, output, 1: the head entry's PC had `pc[1:0] != 0`.
- `stall_out`, output, 1: to fetch `stall_in`; requests that fetch hold its PC.
- `count_out`, output, $clog2(DEPTH)+1: current occupancy.
- `overflow_out`, output, 1: sticky; a push was dropped. Cleared only by reset.

## Operation
- Storage: circular buffer of DEPTH × 65 bits {misaligned, pc, insn}, with read pointer, write pointer and occupancy count.
- Push condition: `valid_in && !flush_in && (count < DEPTH || pop)`.
  - The entry is written at the write pointer.
  - The misaligned bit is `|pc_in[1:0]`.
- Pop condition: `valid_out && ready_in && !flush_in`. The read pointer advances.
- Count update: count += push − pop.
  - Simultaneous push and pop leaves count unchanged.
  - Push into a full queue is accepted only with a simultaneous pop.
- Drop: `valid_in` with a full queue, no pop and no flush drops the word and sets `overflow_out`. Nothing else changes.
- Flush: read pointer, write pointer and count go to 0 on that edge. `valid_in` and `ready_in` are ignored that cycle. `overflow_out` is kept.
- `stall_out = (count >= DEPTH-1)`, combinational from registered count.
  - One slot of slack covers the fact that fetch registers its PC output one cycle after it samples `stall_in`.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Empty queue: `pc_out = PC_RESET`, `insn_out = 0`, `misaligned_out = 0`, `valid_out = 0` (except in bypass, see Configuration).
- Reset, including mid-operation: pointers 0, count 0, `overflow_out` 0, `valid_out` 0, `stall_out` 0, `count_out` 0, `pc_out = PC_RESET`, `insn_out` 0. Storage contents are don't-care.

## Timing
- Push-to-visible latency is 1 cycle: an entry pushed at edge N drives `valid_out`/`pc_out`/`insn_out` after edge N.
- The handshake is registered on the edge where `valid_out && ready_in` are both high. The head is replaced by the next entry (or empty) after that edge.
- Decode must not see the head outputs change while `valid_out` is high and `ready_in` is low.
- `stall_out` reflects count after each edge, with no additional register stage.
- Maximum throughput is one push and one pop per cycle, sustained.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When count == 0 and `valid_in` is high (no flush), the outputs show `pc_in`/`insn_in` combinationally with `valid_out = 1`.
  - If `ready_in` is also high, the word is consumed that cycle and not stored. Count stays 0.
  - If `ready_in` is low, the word is stored normally.
- Not defined: no combinational path from inputs to `valid_out`/`pc_out`/`insn_out`; latency is always 1 cycle.

## Test plan
- Reset mid-stream:
  - Stimulus: push 3 entries, then pulse `rst_in` between edges.
  - Required: `valid_out`, `count_out` and `stall_out` go to 0 immediately; `pc_out = PC_RESET`.
- In-order fill and drain, DEPTH=4:
  - Stimulus: push PCs 0x80020000 to 0x8002000C with insns 0x11111111 to 0x44444444, `ready_in` = 0.
  - Required: `stall_out` rises when count reaches 3. Then raise `ready_in`; 4 pops return in order; count reaches 0.
- Full queue with simultaneous push and pop:
  - Stimulus: at count = 4, `valid_in` (pc 0x80020010) with `ready_in`.
  - Required: count stays 4 and `overflow_out` stays 0. The next cycle with push and no pop drops the word and sets `overflow_out` = 1.
- Flush with push:
  - Stimulus: with count = 2, assert `flush_in` together with `valid_in`.
  - Required: count = 0 and `valid_out` = 0 after the edge. The pushed word never appears.
- Wrap-around and misaligned PC:
  - Stimulus: 10 push/pop pairs with one PC of 0x80020006.
  - Required: order preserved across the pointer wrap. `misaligned_out` = 1 only on that entry.
- Bypass (only with `FETCH_QUEUE_BYPASS_EN`):
  - Stimulus: empty queue, `valid_in` with pc 0x80020000 and `ready_in` = 1.
  - Required: `valid_out` = 1 in the same cycle, `pc_out` = 0x80020000, count stays 0.
